// File: rtl/fp16_add_seq_if.sv
// Operand/result handshake bundle for the sequential FP16 adder.
interface fp16_add_seq_if;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] a;
  logic [15:0] b;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] sum;
  logic        ovf;
  logic        uf;

  modport master (
    output in_valid, a, b, out_ready,
    input  in_ready, out_valid, sum, ovf, uf
  );

  modport slave (
    input  in_valid, a, b, out_ready,
    output in_ready, out_valid, sum, ovf, uf
  );
endinterface

// File: rtl/fp16_add_seq.sv
// Multi-cycle FP16 adder: compare/swap, one-bit-per-cycle align, add,
// one-bit-per-cycle normalize. Subnormals are treated as zero, results
// are truncated, Inf/NaN inputs give an undefined result.
module fp16_add_seq (
  input  logic           clk,
  input  logic           rst,
  fp16_add_seq_if.slave  io
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CMP,
    S_ALIGN,
    S_ADD,
    S_NORM,
    S_DONE
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] op_a_q, op_a_d;
  logic [15:0] op_b_q, op_b_d;
  logic        sign_q, sign_d;
  logic        sub_q, sub_d;
  logic [4:0]  exp_q, exp_d;
  logic [10:0] sig_l_q, sig_l_d;
  logic [10:0] sig_s_q, sig_s_d;
  logic [4:0]  d_q, d_d;
  logic [11:0] r_q, r_d;
  logic [15:0] sum_q, sum_d;
  logic        ovf_q, ovf_d;
  logic        uf_q, uf_d;

  // Zero exponent decodes as zero; otherwise prepend the hidden bit.
  function automatic logic [10:0] sig_of(input logic [15:0] x);
    return (x[14:10] == 5'd0) ? 11'd0 : {1'b1, x[9:0]};
  endfunction

  logic [15:0] mag_a, mag_b;
  logic        b_larger;
  logic [15:0] l_op, s_op;
  logic [4:0]  diff;
  logic [4:0]  exp_inc;

  assign mag_a    = {op_a_q[14:10], sig_of(op_a_q)};
  assign mag_b    = {op_b_q[14:10], sig_of(op_b_q)};
  assign b_larger = (mag_b > mag_a);
  assign l_op     = b_larger ? op_b_q : op_a_q;
  assign s_op     = b_larger ? op_a_q : op_b_q;
  assign diff     = l_op[14:10] - s_op[14:10];
  assign exp_inc  = exp_q + 5'd1;

  assign io.in_ready  = (state_q == S_IDLE);
  assign io.out_valid = (state_q == S_DONE);
  assign io.sum       = sum_q;
  assign io.ovf       = ovf_q;
  assign io.uf        = uf_q;

  // State and datapath registers; reset abandons any operation in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      op_a_q  <= '0;
      op_b_q  <= '0;
      sign_q  <= 1'b0;
      sub_q   <= 1'b0;
      exp_q   <= '0;
      sig_l_q <= '0;
      sig_s_q <= '0;
      d_q     <= '0;
      r_q     <= '0;
      sum_q   <= '0;
      ovf_q   <= 1'b0;
      uf_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      op_a_q  <= op_a_d;
      op_b_q  <= op_b_d;
      sign_q  <= sign_d;
      sub_q   <= sub_d;
      exp_q   <= exp_d;
      sig_l_q <= sig_l_d;
      sig_s_q <= sig_s_d;
      d_q     <= d_d;
      r_q     <= r_d;
      sum_q   <= sum_d;
      ovf_q   <= ovf_d;
      uf_q    <= uf_d;
    end
  end

  // Next-state and per-step datapath update; every register holds by default.
  always_comb begin
    state_d = state_q;
    op_a_d  = op_a_q;
    op_b_d  = op_b_q;
    sign_d  = sign_q;
    sub_d   = sub_q;
    exp_d   = exp_q;
    sig_l_d = sig_l_q;
    sig_s_d = sig_s_q;
    d_d     = d_q;
    r_d     = r_q;
    sum_d   = sum_q;
    ovf_d   = ovf_q;
    uf_d    = uf_q;

    unique case (state_q)
      S_IDLE: begin
        if (io.in_valid) begin
          op_a_d  = io.a;
          op_b_d  = io.b;
          state_d = S_CMP;
        end
      end

      S_CMP: begin
        sign_d  = l_op[15];
        sub_d   = l_op[15] ^ s_op[15];
        exp_d   = l_op[14:10];
        sig_l_d = sig_of(l_op);
        // A gap beyond 11 shifts every bit out, so skip ALIGN entirely.
        if (diff > 5'd11) begin
          sig_s_d = '0;
          d_d     = '0;
          state_d = S_ADD;
        end else begin
          sig_s_d = sig_of(s_op);
          d_d     = diff;
          state_d = (diff != 5'd0) ? S_ALIGN : S_ADD;
        end
      end

      S_ALIGN: begin
        sig_s_d = sig_s_q >> 1;
        d_d     = d_q - 5'd1;
        if (d_q == 5'd1) state_d = S_ADD;
      end

      S_ADD: begin
        r_d     = sub_q ? ({1'b0, sig_l_q} - {1'b0, sig_s_q})
                        : ({1'b0, sig_l_q} + {1'b0, sig_s_q});
        state_d = S_NORM;
      end

      S_NORM: begin
        if (r_q == 12'd0) begin
          sum_d   = '0;
          ovf_d   = 1'b0;
          uf_d    = 1'b0;
          state_d = S_DONE;
        end else if (r_q[11]) begin
          // Carry out: the fraction after the right shift is r[10:1].
          exp_d   = exp_inc;
          r_d     = r_q >> 1;
          uf_d    = 1'b0;
          if (exp_inc == 5'd31) begin
            sum_d = {sign_q, 5'h1F, 10'd0};
            ovf_d = 1'b1;
          end else begin
            sum_d = {sign_q, exp_inc, r_q[10:1]};
            ovf_d = 1'b0;
          end
          state_d = S_DONE;
        end else if (r_q[10]) begin
          sum_d   = {sign_q, exp_q, r_q[9:0]};
          ovf_d   = 1'b0;
          uf_d    = 1'b0;
          state_d = S_DONE;
        end else if (exp_q <= 5'd1) begin
          sum_d   = '0;
          ovf_d   = 1'b0;
          uf_d    = 1'b1;
          state_d = S_DONE;
        end else begin
          r_d   = r_q << 1;
          exp_d = exp_q - 5'd1;
        end
      end

      S_DONE: begin
        if (io.out_ready) state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_fp16_add_seq.sv
// Directed-vector bench for fp16_add_seq.
module tb_fp16_add_seq;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks   = 0;
  int   failures = 0;

  fp16_add_seq_if bus ();

  fp16_add_seq dut (
    .clk (clk),
    .rst (rst),
    .io  (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] s;
    logic        o;
    logic        u;
    int          lat;
  } vec_t;

  // Present one pair, wait for out_valid; lat is the cycle index counted
  // from the accept edge (1 = the cycle right after it), -1 on timeout.
  task automatic run_op(input logic [15:0] op_a, input logic [15:0] op_b,
                        input bit handshake, output logic [15:0] s,
                        output logic o, output logic u, output int lat);
    int n;
    bus.a        = op_a;
    bus.b        = op_b;
    bus.in_valid = 1'b1;
    n = 0;
    while (!bus.in_ready && n < 50) begin
      @(posedge clk); #1; n++;
    end
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    lat = 1;
    while (!bus.out_valid && lat < 40) begin
      @(posedge clk); #1; lat++;
    end
    if (!bus.out_valid) lat = -1;
    s = bus.sum;
    o = bus.ovf;
    u = bus.uf;
    if (handshake) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b exp=1", bus.in_ready); end
    checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", bus.out_valid); end
    checks++; if (bus.sum !== 16'h0000) begin failures++; $display("FAIL reset_sum got=%h exp=0000", bus.sum); end
    checks++; if (bus.ovf !== 1'b0) begin failures++; $display("FAIL reset_ovf got=%b exp=0", bus.ovf); end
    checks++; if (bus.uf !== 1'b0) begin failures++; $display("FAIL reset_uf got=%b exp=0", bus.uf); end
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_vectors();
    vec_t        v[13];
    logic [15:0] s;
    logic        o, u;
    int          lat;
    v[0]  = '{16'h3C00, 16'h3C00, 16'h4000, 1'b0, 1'b0, 4};   // 1 + 1
    v[1]  = '{16'h3C00, 16'h3800, 16'h3E00, 1'b0, 1'b0, 5};   // 1 + 0.5
    v[2]  = '{16'h3800, 16'h3C00, 16'h3E00, 1'b0, 1'b0, 5};   // swap path
    v[3]  = '{16'h3C00, 16'hBA00, 16'h3400, 1'b0, 1'b0, 7};   // 1 - 0.75
    v[4]  = '{16'h3C00, 16'hBC00, 16'h0000, 1'b0, 1'b0, 4};   // exact cancel
    v[5]  = '{16'h3800, 16'hBC00, 16'hB800, 1'b0, 1'b0, 6};   // negative result
    v[6]  = '{16'hBC00, 16'hBC00, 16'hC000, 1'b0, 1'b0, 4};   // -1 + -1
    v[7]  = '{16'h7BFF, 16'h7BFF, 16'h7C00, 1'b1, 1'b0, 4};   // overflow
    v[8]  = '{16'h0600, 16'h8400, 16'h0000, 1'b0, 1'b1, 4};   // underflow flush
    v[9]  = '{16'h6400, 16'h0400, 16'h6400, 1'b0, 1'b0, 4};   // d=24 clamp
    v[10] = '{16'h3C00, 16'h1000, 16'h3C00, 1'b0, 1'b0, 15};  // d=11 full align
    v[11] = '{16'h3C00, 16'h0C00, 16'h3C00, 1'b0, 1'b0, 4};   // d=12 clamp
    v[12] = '{16'h3C00, 16'hBBFF, 16'h1400, 1'b0, 1'b0, 15};  // 10 left shifts
    bus.out_ready = 1'b1;
    for (int i = 0; i < 13; i++) begin
      run_op(v[i].a, v[i].b, 1'b1, s, o, u, lat);
      checks++; if (s !== v[i].s) begin failures++; $display("FAIL vec%0d_sum a=%h b=%h got=%h exp=%h", i, v[i].a, v[i].b, s, v[i].s); end
      checks++; if (o !== v[i].o) begin failures++; $display("FAIL vec%0d_ovf got=%b exp=%b", i, o, v[i].o); end
      checks++; if (u !== v[i].u) begin failures++; $display("FAIL vec%0d_uf got=%b exp=%b", i, u, v[i].u); end
      checks++; if (lat !== v[i].lat) begin failures++; $display("FAIL vec%0d_latency got=%0d exp=%0d", i, lat, v[i].lat); end
    end
  endtask

  task automatic test_backpressure();
    logic [15:0] s;
    logic        o, u;
    int          lat;
    bus.out_ready = 1'b0;
    run_op(16'h3C00, 16'h3800, 1'b0, s, o, u, lat);
    checks++; if (s !== 16'h3E00) begin failures++; $display("FAIL bp_sum got=%h exp=3E00", s); end
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      checks++; if (bus.out_valid !== 1'b1) begin failures++; $display("FAIL bp_out_valid cyc=%0d got=%b exp=1", i, bus.out_valid); end
      checks++; if (bus.in_ready !== 1'b0) begin failures++; $display("FAIL bp_in_ready cyc=%0d got=%b exp=0", i, bus.in_ready); end
      checks++; if ({bus.sum, bus.ovf, bus.uf} !== {16'h3E00, 2'b00}) begin failures++; $display("FAIL bp_hold cyc=%0d got=%h/%b/%b exp=3E00/0/0", i, bus.sum, bus.ovf, bus.uf); end
    end
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    checks++; if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL bp_release_in_ready got=%b exp=1", bus.in_ready); end
    checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL bp_release_out_valid got=%b exp=0", bus.out_valid); end
  endtask

  task automatic test_back_to_back();
    logic [15:0] s;
    logic        o, u;
    int          lat;
    bus.out_ready = 1'b1;
    run_op(16'h3C00, 16'h3C00, 1'b1, s, o, u, lat);
    checks++; if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL b2b_in_ready got=%b exp=1", bus.in_ready); end
    run_op(16'h3C00, 16'h3800, 1'b1, s, o, u, lat);
    checks++; if (s !== 16'h3E00) begin failures++; $display("FAIL b2b_sum got=%h exp=3E00", s); end
    checks++; if (lat !== 5) begin failures++; $display("FAIL b2b_latency got=%0d exp=5", lat); end
  endtask

  task automatic test_reset_mid_align();
    logic [15:0] s;
    logic        o, u;
    int          lat;
    bit          seen;
    bus.out_ready = 1'b1;
    bus.a         = 16'h3C00;
    bus.b         = 16'h1400;
    bus.in_valid  = 1'b1;
    @(posedge clk); #1;            // accept edge; now cycle 1 (CMP)
    bus.in_valid = 1'b0;
    @(posedge clk); #1;            // cycle 2
    @(posedge clk); #1;            // cycle 3 (ALIGN)
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checks++; if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL rst_mid_in_ready got=%b exp=1", bus.in_ready); end
    checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL rst_mid_out_valid got=%b exp=0", bus.out_valid); end
    seen = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(posedge clk); #1;
      if (bus.out_valid) seen = 1'b1;
    end
    checks++; if (seen !== 1'b0) begin failures++; $display("FAIL rst_mid_no_result got=%b exp=0", seen); end
    run_op(16'h3C00, 16'h3C00, 1'b1, s, o, u, lat);
    checks++; if (s !== 16'h4000) begin failures++; $display("FAIL rst_mid_after_sum got=%h exp=4000", s); end
    checks++; if (lat !== 4) begin failures++; $display("FAIL rst_mid_after_latency got=%0d exp=4", lat); end
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.a         = '0;
    bus.b         = '0;
    bus.out_ready = 1'b1;
    test_reset();
    test_vectors();
    test_backpressure();
    test_back_to_back();
    test_reset_mid_align();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
